// File: rtl/common_pkg.sv
// common_pkg: shared NoC defaults used by the link-level blocks.
//   DEFAULT_VC_W          - number of virtual channels per link
//   DEFAULT_VC_FIFO_DEPTH - per-VC depth; usable capacity is DEPTH-1 flits
//   DEFAULT_FLIT_W        - flit payload width in bits
package common_pkg;
  localparam int DEFAULT_VC_W          = 4;
  localparam int DEFAULT_VC_FIFO_DEPTH = 4;
  localparam int DEFAULT_FLIT_W        = 32;
endpackage

// File: rtl/vc_fifo.sv
// vc_fifo: single-VC circular FIFO holding DEPTH-1 flits.
// Ports:
//   i_clk, i_rst     - clock, synchronous active-high reset
//   i_push, i_data   - write request and payload (dropped when full)
//   i_pop            - read request (ignored when empty)
//   o_valid, o_data  - non-empty flag and head word
//   o_count          - occupancy 0..DEPTH-1
//   o_pop_eff        - pop actually performed this cycle
//   o_ovf_strb       - write attempted while full (one cycle)
module vc_fifo
  import common_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_VC_FIFO_DEPTH,
  parameter int FLIT_W = DEFAULT_FLIT_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [FLIT_W-1:0] o_data,
  output logic [PTR_W-1:0]  o_count,
  output logic              o_pop_eff,
  output logic              o_ovf_strb
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-2);
  localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH-1);

  logic [FLIT_W-1:0] mem [DEPTH-1];
  logic [PTR_W-1:0]  head, tail, count;
  logic              full, wr, rd;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count == FULL);
  assign o_valid    = (count != '0);
  assign wr         = i_push & ~full;
  assign rd         = i_pop & o_valid;
  assign o_pop_eff  = rd;
  assign o_ovf_strb = i_push & full;
  assign o_data     = mem[head];
  assign o_count    = count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr) tail <= nxt(tail);
      if (rd) head <= nxt(head);
      // push+pop together leaves count unchanged; slots differ since count>=1
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage is intentionally not reset
  always_ff @(posedge i_clk) begin
    if (wr) mem[tail] <= i_data;
  end
endmodule

// File: rtl/vc_rx_buffer.sv
// vc_rx_buffer: receive-side VC input buffer terminating one NoC link.
// One vc_fifo per VC; each effective pop returns one credit pulse upstream.
// Ports:
//   i_clk, i_rst      - clock, synchronous active-high reset
//   i_flit_valid      - flit present on link
//   i_flit            - flit payload
//   i_vc_sel          - one-hot target VC (all-zero ignored)
//   o_vc_credit_gnt   - per-VC credit return pulse
//   o_vc_valid        - per-VC non-empty
//   o_vc_flit         - per-VC head flit
//   i_vc_pop          - per-VC pop request
//   o_vc_count        - per-VC occupancy
//   o_overflow        - sticky: write hit a full VC
// Build option: define VC_RX_CREDIT_REG_EN to register o_vc_credit_gnt
// (pulse one cycle after the pop); otherwise it is combinational.
module vc_rx_buffer
  import common_pkg::*;
#(
  parameter int VC_W   = DEFAULT_VC_W,
  parameter int DEPTH  = DEFAULT_VC_FIFO_DEPTH,
  parameter int FLIT_W = DEFAULT_FLIT_W,
  localparam int CNT_W = $clog2(DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flit_valid,
  input  logic [FLIT_W-1:0]            i_flit,
  input  logic [VC_W-1:0]              i_vc_sel,
  output logic [VC_W-1:0]              o_vc_credit_gnt,
  output logic [VC_W-1:0]              o_vc_valid,
  output logic [VC_W-1:0][FLIT_W-1:0]  o_vc_flit,
  input  logic [VC_W-1:0]              i_vc_pop,
  output logic [VC_W-1:0][CNT_W-1:0]   o_vc_count,
  output logic                         o_overflow
);
  logic [VC_W-1:0] push, pop_eff, ovf_strb;

  assign push = {VC_W{i_flit_valid}} & i_vc_sel;

  for (genvar v = 0; v < VC_W; v++) begin : g_vc
    vc_fifo #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) u_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push     (push[v]),
      .i_data     (i_flit),
      .i_pop      (i_vc_pop[v]),
      .o_valid    (o_vc_valid[v]),
      .o_data     (o_vc_flit[v]),
      .o_count    (o_vc_count[v]),
      .o_pop_eff  (pop_eff[v]),
      .o_ovf_strb (ovf_strb[v])
    );
  end

`ifdef VC_RX_CREDIT_REG_EN
  logic [VC_W-1:0] credit_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) credit_q <= '0;
    else       credit_q <= pop_eff;
  end
  assign o_vc_credit_gnt = credit_q;
`else
  assign o_vc_credit_gnt = pop_eff;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst)          o_overflow <= 1'b0;
    else if (|ovf_strb) o_overflow <= 1'b1;
  end

`ifdef SIMULATION
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert ($onehot0(i_vc_sel)) else $error("vc_sel not onehot0");
      assert (!i_flit_valid || (i_vc_sel != '0)) else $error("flit_valid with empty vc_sel");
      assert (!$isunknown({i_flit_valid, i_vc_pop, o_vc_valid, o_vc_credit_gnt, o_overflow}))
        else $error("X on control");
      for (int v = 0; v < VC_W; v++)
        assert (int'(o_vc_count[v]) <= DEPTH-1) else $error("count above capacity");
      assert (!o_overflow) else $error("overflow raised");
    end
  end
`endif
endmodule
